// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the cache / physical-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 16;
    localparam int unsigned ARB_LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_A,
        SERVE_B
    } arb_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_sel_t;

    typedef logic [ARB_LINE_W-1:0] line_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic      req_a,
    input  logic      req_b,
    input  port_sel_t last_grant,
    output logic      grant_valid,
    output port_sel_t grant_sel
);

    // Winner selection for the current request pair
    always_comb begin
        grant_valid = req_a | req_b;
        grant_sel   = PORT_A;
        if (req_a && req_b) begin
            grant_sel = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant_sel = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache (port a) and D-cache (port b) line requests onto a single
// physical-memory port, one transaction in flight, round-robin on ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_a,
    input  logic              mem_write_a,
    input  logic [ADDR_W-1:0] mem_addr_a,
    input  logic [LINE_W-1:0] mem_wdata_a,
    output logic [LINE_W-1:0] mem_rdata_a,
    output logic              mem_resp_a,
    input  logic              mem_read_b,
    input  logic              mem_write_b,
    input  logic [ADDR_W-1:0] mem_addr_b,
    input  logic [LINE_W-1:0] mem_wdata_b,
    output logic [LINE_W-1:0] mem_rdata_b,
    output logic              mem_resp_b,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state;
    port_sel_t  last_grant;
    logic       op_write;
    logic       grant_valid;
    port_sel_t  grant_sel;
    logic       win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [LINE_W-1:0] win_wdata;

    rr_pick2 u_pick (
        .req_a       (mem_read_a | mem_write_a),
        .req_b       (mem_read_b | mem_write_b),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    // Operands of the port that wins this cycle; read+write together is a write
    always_comb begin
        win_write = (grant_sel == PORT_A) ? mem_write_a : mem_write_b;
        win_addr  = (grant_sel == PORT_A) ? mem_addr_a  : mem_addr_b;
        win_wdata = (grant_sel == PORT_A) ? mem_wdata_a : mem_wdata_b;
    end

    // Arbitration FSM; strobes, address and write data are registered at the grant edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= PORT_A;
            op_write     <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state        <= (grant_sel == PORT_A) ? SERVE_A : SERVE_B;
                        last_grant   <= grant_sel;
                        op_write     <= win_write;
                        pmem_read    <= ~win_write;
                        pmem_write   <= win_write;
                        pmem_address <= win_addr;
                        pmem_wdata   <= win_wdata;
                    end
                end
                SERVE_A, SERVE_B: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // Completion is combinational with pmem_resp; suppressed while reset is asserted
    always_comb begin
        mem_resp_a  = ~rst & pmem_resp & (state == SERVE_A);
        mem_resp_b  = ~rst & pmem_resp & (state == SERVE_B);
        mem_rdata_a = (mem_resp_a && !op_write) ? pmem_rdata : '0;
        mem_rdata_b = (mem_resp_b && !op_write) ? pmem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: requesters and a memory
// responder are driven from one stimulus loop that also runs a transaction-level
// model; expected grants and responses are queued and checked by a monitor.
module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 128;
    localparam int unsigned NCYC = 4000;

    typedef struct {
        int          port;
        logic        wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } gnt_t;

    typedef struct {
        int          port;
        logic [LW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic          rd    [2];
    logic          wr    [2];
    logic [AW-1:0] addr  [2];
    logic [LW-1:0] wdata [2];
    logic [LW-1:0] mem_rdata_a, mem_rdata_b;
    logic          mem_resp_a, mem_resp_b;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    gnt_t grant_q[$];
    rsp_t resp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic rst_q = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_a   (rd[0]),
        .mem_write_a  (wr[0]),
        .mem_addr_a   (addr[0]),
        .mem_wdata_a  (wdata[0]),
        .mem_rdata_a  (mem_rdata_a),
        .mem_resp_a   (mem_resp_a),
        .mem_read_b   (rd[1]),
        .mem_write_b  (wr[1]),
        .mem_addr_b   (addr[1]),
        .mem_wdata_b  (wdata[1]),
        .mem_rdata_b  (mem_rdata_b),
        .mem_resp_b   (mem_resp_b),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) rst_q <= rst;

    // Stimulus + transaction-level reference model
    initial begin
        bit   busy = 0;
        int   cur_port = 0;
        logic cur_wr = 0;
        int   last = 0;
        int   wait_cnt = 0;
        bit   pending [2];
        // Both ports request throughout reset; port a at 0x0040, port b at 0x1230
        rd[0] = 1; wr[0] = 0; addr[0] = 16'h0040; wdata[0] = '0;
        rd[1] = 1; wr[1] = 0; addr[1] = 16'h1230; wdata[1] = 128'h1;
        pending[0] = 1; pending[1] = 1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            // What the arbiter does at this edge, from the protocol rules
            if (rst) begin
                busy = 0;
                last = 0;
                for (int p = 0; p < 2; p++) pending[p] = rd[p] | wr[p];
            end else if (busy) begin
                if (pmem_resp) begin
                    busy = 0;
                    pending[cur_port] = 0;
                    rd[cur_port] = 0;
                    wr[cur_port] = 0;
                end
            end else if (rd[0] | wr[0] | rd[1] | wr[1]) begin
                int w;
                if ((rd[0] | wr[0]) && (rd[1] | wr[1])) w = 1 - last;
                else w = (rd[0] | wr[0]) ? 0 : 1;
                last = w;
                busy = 1;
                cur_port = w;
                cur_wr = wr[w];
                grant_q.push_back('{port: w, wr: wr[w], addr: addr[w], wdata: wdata[w]});
                wait_cnt = $urandom_range(0, 4);
            end
            #1;
            if (cyc < 2) rst = 1;
            else if (cyc >= 300) rst = ($urandom_range(0, 63) == 0);
            else rst = 0;
            // Memory responder
            pmem_resp  = 0;
            pmem_rdata = rand_line();
            if (busy && !rst) begin
                if (wait_cnt == 0) begin
                    pmem_resp = 1;
                    resp_q.push_back('{port: cur_port, data: cur_wr ? '0 : pmem_rdata});
                end else begin
                    wait_cnt--;
                end
            end else if (!busy && $urandom_range(0, 3) == 0) begin
                pmem_resp = 1;
            end
            // Requesters
            if (cyc >= 3) begin
                for (int p = 0; p < 2; p++) begin
                    if (!pending[p]) begin
                        if (cyc < 300 || $urandom_range(0, 1) == 0) begin
                            int op = $urandom_range(0, 2);
                            pending[p] = 1;
                            rd[p]    = (op != 1);
                            wr[p]    = (op != 0);
                            addr[p]  = 16'($urandom);
                            wdata[p] = rand_line();
                        end
                    end else if (busy && cur_port == p) begin
                        if ($urandom_range(0, 2) == 0) begin
                            addr[p]  = 16'($urandom);
                            wdata[p] = rand_line();
                        end
                        if ($urandom_range(0, 7) == 0) begin
                            rd[p] = 0;
                            wr[p] = 0;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        rst = 1;
        pmem_resp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: pops expectations whenever the DUT presents a strobe or response
    initial begin
        logic prev_strobe = 0;
        bit   cur_valid = 0;
        gnt_t cur;
        gnt_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                vectors++;
                if ({pmem_read, pmem_write, mem_resp_a, mem_resp_b} != 4'b0 ||
                    pmem_address != '0 || pmem_wdata != '0 ||
                    mem_rdata_a != '0 || mem_rdata_b != '0) begin
                    miscompares++;
                    $display("FAIL reset_outputs: rd=%b wr=%b addr=%h resp_a=%b resp_b=%b, required all 0",
                             pmem_read, pmem_write, pmem_address, mem_resp_a, mem_resp_b);
                end
                cur_valid = 0;
            end else begin
                logic strobe;
                strobe = pmem_read | pmem_write;
                if (grant_q.size() != 0) begin
                    g = grant_q.pop_front();
                    vectors++;
                    if (!(strobe && !prev_strobe)) begin
                        miscompares++;
                        $display("FAIL grant_start: strobe=%b prev=%b, required rising strobe for port %0d addr %h",
                                 strobe, prev_strobe, g.port, g.addr);
                    end else if (pmem_write != g.wr || pmem_read != !g.wr ||
                                 pmem_address != g.addr || pmem_wdata != g.wdata) begin
                        miscompares++;
                        $display("FAIL grant_fields: got rd=%b wr=%b addr=%h wdata=%h, required port %0d wr=%b addr=%h wdata=%h",
                                 pmem_read, pmem_write, pmem_address, pmem_wdata, g.port, g.wr, g.addr, g.wdata);
                    end
                    cur = g;
                    cur_valid = 1;
                end else if (strobe) begin
                    vectors++;
                    if (!prev_strobe || !cur_valid) begin
                        miscompares++;
                        $display("FAIL unexpected_strobe: rd=%b wr=%b addr=%h, required no strobe",
                                 pmem_read, pmem_write, pmem_address);
                    end else if (pmem_write != cur.wr || pmem_read != !cur.wr ||
                                 pmem_address != cur.addr || pmem_wdata != cur.wdata) begin
                        miscompares++;
                        $display("FAIL strobe_hold: got rd=%b wr=%b addr=%h, required wr=%b addr=%h",
                                 pmem_read, pmem_write, pmem_address, cur.wr, cur.addr);
                    end
                end
                prev_strobe = strobe;
            end
            if (rst_q) prev_strobe = 0;

            if (mem_resp_a || mem_resp_b) begin
                vectors++;
                if (resp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_resp: resp_a=%b resp_b=%b, required none", mem_resp_a, mem_resp_b);
                end else begin
                    logic [LW-1:0] got;
                    r = resp_q.pop_front();
                    got = (r.port == 0) ? mem_rdata_a : mem_rdata_b;
                    if (mem_resp_a && mem_resp_b) begin
                        miscompares++;
                        $display("FAIL resp_both: resp_a=1 resp_b=1, required only port %0d", r.port);
                    end else if ((r.port == 0) != mem_resp_a) begin
                        miscompares++;
                        $display("FAIL resp_port: resp_a=%b resp_b=%b, required port %0d",
                                 mem_resp_a, mem_resp_b, r.port);
                    end else if (got != r.data) begin
                        miscompares++;
                        $display("FAIL resp_data: port %0d got %h, required %h", r.port, got, r.data);
                    end
                end
            end else if (resp_q.size() != 0) begin
                r = resp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL resp_missing: resp_a=0 resp_b=0, required resp on port %0d", r.port);
            end
        end
    end

endmodule
